uart_tx_ctrl: RTL and testbench

Transmit-side sequencer for the UART baud-clock generator. Accepts one byte per valid/ready handshake from the TX FIFO/APB side and owns the generator's tx_bclk_en. It counts bclk_tx ticks to time each bit and serialises a frame on txd: start bit, 5–8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It sits between the APB register/FIFO logic and the UART pin.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, data-length codes
// and frame-size helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam int MAX_FRAME_BITS = 12;
  localparam int FRAME_CNT_W    = $clog2(MAX_FRAME_BITS);

  function automatic logic [FRAME_CNT_W-1:0] data_bits(input logic [1:0] len);
    data_bits = FRAME_CNT_W'(8);
    case (len)
      LEN_5:   data_bits = FRAME_CNT_W'(5);
      LEN_6:   data_bits = FRAME_CNT_W'(6);
      LEN_7:   data_bits = FRAME_CNT_W'(7);
      LEN_8:   data_bits = FRAME_CNT_W'(8);
      default: data_bits = FRAME_CNT_W'(8);
    endcase
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] len);
    data_mask = 8'hFF;
    case (len)
      LEN_5:   data_mask = 8'h1F;
      LEN_6:   data_mask = 8'h3F;
      LEN_7:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks and strobes o_bit_end on the tick that completes a bit
// period of OSR ticks.
module uart_bit_timer #(
  parameter int OSR    = 16,
  parameter int TICK_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tick,
  output logic o_bit_end
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OSR - 1);

  logic [TICK_W-1:0] r_tick_cnt;

  assign o_bit_end = i_en & i_tick & (r_tick_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (i_clr || o_bit_end) begin
      r_tick_cnt <= '0;
    end else if (i_en && i_tick) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte by valid/ready, gates the baud
// generator and serialises start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OSR    = 16,
  parameter int TICK_W = 8
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] cfg_data_len,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  input  logic       cfg_stop2,
  input  logic       bclk_tx,
  output logic       tx_bclk_en,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t              r_state, w_state_next;
  logic [7:0]             r_shift, w_shift_next;
  logic [FRAME_CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic [1:0]             r_len, w_len_next;
  logic                   r_par_en, w_par_en_next;
  logic                   r_parity, w_parity_next;
  logic                   r_stop2, w_stop2_next;
  logic                   r_stop_cnt, w_stop_cnt_next;
  logic                   r_txd, w_txd_next;
  logic                   r_bclk_en, w_bclk_en_next;
  logic                   r_done, w_done_next;
  logic                   w_accept;
  logic                   w_bit_end;

  assign tx_ready   = (r_state == ST_IDLE);
  assign tx_busy    = (r_state != ST_IDLE);
  assign txd        = r_txd;
  assign tx_bclk_en = r_bclk_en;
  assign tx_done    = r_done;
  assign w_accept   = tx_ready & tx_valid;

  uart_bit_timer #(
    .OSR   (OSR),
    .TICK_W(TICK_W)
  ) u_bit_timer (
    .clk      (pclk),
    .rst      (preset),
    .i_clr    (w_accept),
    .i_en     (tx_busy),
    .i_tick   (bclk_tx),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_len      <= '0;
      r_par_en   <= 1'b0;
      r_parity   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_bclk_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_len      <= w_len_next;
      r_par_en   <= w_par_en_next;
      r_parity   <= w_parity_next;
      r_stop2    <= w_stop2_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_txd      <= w_txd_next;
      r_bclk_en  <= w_bclk_en_next;
      r_done     <= w_done_next;
    end
  end

  // r_bit_cnt is the index of the frame bit on the line: 0 = start, 1..N = data.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_len_next      = r_len;
    w_par_en_next   = r_par_en;
    w_parity_next   = r_parity;
    w_stop2_next    = r_stop2;
    w_stop_cnt_next = r_stop_cnt;
    w_txd_next      = r_txd;
    w_bclk_en_next  = r_bclk_en;
    w_done_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next    = ST_START;
          w_shift_next    = tx_data;
          w_bit_cnt_next  = '0;
          w_len_next      = cfg_data_len;
          w_par_en_next   = cfg_parity_en;
          w_parity_next   = (^(tx_data & data_mask(cfg_data_len))) ^ cfg_parity_odd;
          w_stop2_next    = cfg_stop2;
          w_stop_cnt_next = 1'b0;
          w_txd_next      = 1'b0;
          w_bclk_en_next  = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_txd_next     = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == data_bits(r_len)) begin
            if (r_par_en) begin
              w_state_next = ST_PARITY;
              w_txd_next   = r_parity;
            end else begin
              w_state_next    = ST_STOP;
              w_txd_next      = 1'b1;
              w_stop_cnt_next = 1'b0;
            end
          end else begin
            w_txd_next   = r_shift[0];
            w_shift_next = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next    = ST_STOP;
          w_txd_next      = 1'b1;
          w_stop_cnt_next = 1'b0;
          w_bit_cnt_next  = r_bit_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_next = 1'b1;
          end else begin
            w_state_next   = ST_IDLE;
            w_txd_next     = 1'b1;
            w_bclk_en_next = 1'b0;
            w_done_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_txd_next     = 1'b1;
        w_bclk_en_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a baud-generator stand-in, a waveform-level reference
// model checked every cycle, and literal frame expectations for directed cases.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int OSR = 16;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] cfg_data_len = 2'b11;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       bclk_tx;
  logic       tx_bclk_en;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_pass = 0;

  uart_tx_ctrl #(.OSR(OSR), .TICK_W(8)) dut (
    .pclk          (pclk),
    .preset        (preset),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cfg_data_len  (cfg_data_len),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .bclk_tx       (bclk_tx),
    .tx_bclk_en    (tx_bclk_en),
    .txd           (txd),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 pclk = ~pclk;

  // Baud generator stand-in: first tick visible two edges after enable, then every div_val cycles.
  int   div_val = 1;
  int   r_gen_cnt;
  logic r_gen_tick;
  logic r_noise;
  logic noise_en = 1'b0;

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_gen_cnt  <= 0;
      r_gen_tick <= 1'b0;
      r_noise    <= 1'b0;
    end else begin
      r_noise <= 1'($urandom_range(0, 1));
      if (!tx_bclk_en) begin
        r_gen_cnt  <= 0;
        r_gen_tick <= 1'b0;
      end else begin
        r_gen_tick <= (r_gen_cnt == 0);
        r_gen_cnt  <= (r_gen_cnt == div_val - 1) ? 0 : r_gen_cnt + 1;
      end
    end
  end

  // Stray ticks while the generator is disabled must be ignored.
  assign bclk_tx = r_gen_tick | (noise_en & r_noise & ~tx_bclk_en);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: expected txd level for every cycle of the current frame.
  logic m_q[$];
  logic m_txd = 1'b1;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;

  function automatic void build_frame(input logic [7:0] d, input logic [1:0] len,
                                      input logic pe, input logic po, input logic s2,
                                      input int dv);
    logic lv[$];
    int   nd;
    logic p;
    nd = 5 + int'(len);
    p  = po;
    lv.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      lv.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) lv.push_back(p);
    lv.push_back(1'b1);
    if (s2) lv.push_back(1'b1);
    for (int b = 0; b < lv.size(); b++) begin
      int dur;
      dur = (b == 0) ? (OSR - 1) * dv + 2 : OSR * dv;
      for (int c = 0; c < dur; c++) m_q.push_back(lv[b]);
    end
  endfunction

  initial begin
    forever begin
      @(posedge pclk);
      if (preset) begin
        m_q.delete();
        m_txd  = 1'b1;
        m_busy = 1'b0;
        m_done = 1'b0;
      end else if (!m_busy && tx_valid) begin
        build_frame(tx_data, cfg_data_len, cfg_parity_en, cfg_parity_odd, cfg_stop2, div_val);
        m_txd  = m_q.pop_front();
        m_busy = 1'b1;
        m_done = 1'b0;
      end else if (m_q.size() > 0) begin
        m_txd  = m_q.pop_front();
        m_done = 1'b0;
      end else begin
        m_done = m_busy;
        m_busy = 1'b0;
        m_txd  = 1'b1;
      end
    end
  end

  // Per-cycle compare of {txd, tx_bclk_en, tx_busy, tx_ready, tx_done}.
  initial begin
    logic [4:0] exp_v;
    forever begin
      @(negedge pclk);
      if (preset) exp_v = 5'b10010;
      else        exp_v = {m_txd, m_busy, m_busy, ~m_busy, m_done};
      check("cycle", 32'({txd, tx_bclk_en, tx_busy, tx_ready, tx_done}), 32'(exp_v));
    end
  end

  task automatic drive(input logic [7:0] d, input logic [1:0] len, input logic pe,
                       input logic po, input logic s2, input int dv);
    @(negedge pclk);
    div_val        = dv;
    tx_data        = d;
    cfg_data_len   = len;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
    tx_valid       = 1'b1;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic wait_accept(output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20000; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        @(posedge pclk);
        break;
      end
      waited++;
      @(negedge pclk);
    end
    check("accept_in_time", 32'(ok), 32'd1);
  endtask

  // Records txd over the busy cycles and samples each bit at its centre.
  task automatic capture(input int nbits, input int dv, input bit hold, input logic [7:0] nxt,
                         input bit scramble, output int busy_cyc, output int start_cyc,
                         output logic [MAX_FRAME_BITS-1:0] bv);
    logic w[$];
    bit   fin;
    int   s_len;
    int   b_len;
    fin = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge pclk);
      if (c == 0) begin
        tx_valid = hold;
        tx_data  = nxt;
        if (scramble) begin
          cfg_data_len   = 2'($urandom_range(0, 3));
          cfg_parity_en  = 1'($urandom_range(0, 1));
          cfg_parity_odd = 1'($urandom_range(0, 1));
          cfg_stop2      = 1'($urandom_range(0, 1));
        end
      end
      if (!tx_busy) begin
        fin = 1'b1;
        break;
      end
      w.push_back(txd);
    end
    check("frame_ends", 32'(fin), 32'd1);
    busy_cyc  = w.size();
    start_cyc = 0;
    while (start_cyc < w.size() && w[start_cyc] == 1'b0) start_cyc++;
    s_len = (OSR - 1) * dv + 2;
    b_len = OSR * dv;
    bv = '0;
    for (int i = 0; i < nbits; i++) begin
      int pos;
      pos = (i == 0) ? s_len / 2 : s_len + (i - 1) * b_len + b_len / 2;
      if (pos < w.size()) bv[i] = w[pos];
    end
  endtask

  initial begin
    int busy_c;
    int start_c;
    int waited;
    logic [MAX_FRAME_BITS-1:0] bv;

    repeat (3) @(negedge pclk);
    preset = 1'b0;

    // Idle after reset
    repeat (100) @(negedge pclk);
    check("idle_outputs", 32'({txd, tx_bclk_en, tx_ready, tx_busy}), 32'b1010);

    // 8N1 0xA5, div 1
    drive(8'hA5, LEN_8, 1'b0, 1'b0, 1'b0, 1);
    wait_accept(waited);
    capture(10, 1, 1'b0, 8'h00, 1'b0, busy_c, start_c, bv);
    check("a5_bits", 32'(bv), 32'h34A);
    check("a5_start_cycles", 32'(start_c), 32'd17);
    check("a5_frame_cycles", 32'(busy_c), 32'd161);
    check("a5_done_ready", 32'({tx_done, tx_ready}), 32'b11);
    $display("frame 8N1 data=a5 div=1 cycles=%0d bits=%h", busy_c, bv);

    // 7E2 0xFF, div 4
    drive(8'hFF, LEN_7, 1'b1, 1'b0, 1'b1, 4);
    wait_accept(waited);
    capture(11, 4, 1'b0, 8'h00, 1'b0, busy_c, start_c, bv);
    check("7e2_bits", 32'(bv), 32'h7FE);
    check("7e2_start_cycles", 32'(start_c), 32'd62);
    check("7e2_frame_cycles", 32'(busy_c), 32'd702);
    $display("frame 7E2 data=ff div=4 cycles=%0d bits=%h", busy_c, bv);

    // 5O1 0x03, div 2, config scrambled mid-frame
    drive(8'h03, LEN_5, 1'b1, 1'b1, 1'b0, 2);
    wait_accept(waited);
    capture(8, 2, 1'b0, 8'hC7, 1'b1, busy_c, start_c, bv);
    check("5o1_bits", 32'(bv), 32'hC6);
    check("5o1_frame_cycles", 32'(busy_c), 32'd256);
    $display("frame 5O1 data=03 div=2 cycles=%0d bits=%h", busy_c, bv);

    // Back-to-back 0x55 then 0x0F with tx_valid held
    drive(8'h55, LEN_8, 1'b0, 1'b0, 1'b0, 1);
    wait_accept(waited);
    capture(10, 1, 1'b1, 8'h0F, 1'b0, busy_c, start_c, bv);
    check("b2b_first_bits", 32'(bv), 32'h2AA);
    check("b2b_gap_outputs", 32'({tx_bclk_en, tx_done, tx_ready}), 32'b011);
    $display("frame 8N1 data=55 div=1 cycles=%0d bits=%h", busy_c, bv);
    wait_accept(waited);
    check("b2b_idle_gap", 32'(waited), 32'd0);
    capture(10, 1, 1'b0, 8'h00, 1'b0, busy_c, start_c, bv);
    check("b2b_second_bits", 32'(bv), 32'h21E);
    $display("frame 8N1 data=0f div=1 cycles=%0d bits=%h", busy_c, bv);

    // Reset during the data phase of 0x3C
    drive(8'h3C, LEN_8, 1'b0, 1'b0, 1'b0, 1);
    wait_accept(waited);
    @(negedge pclk);
    tx_valid = 1'b0;
    repeat (45) @(negedge pclk);
    check("mid_frame_busy", 32'(tx_busy), 32'd1);
    @(posedge pclk);
    #2 preset = 1'b1;
    #1 check("async_reset_outputs", 32'({txd, tx_bclk_en, tx_busy, tx_done}), 32'b1000);
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    check("no_done_after_reset", 32'(tx_done), 32'd0);
    $display("frame 8N1 data=3c div=1 aborted by reset");
    drive(8'hC3, LEN_8, 1'b0, 1'b0, 1'b0, 1);
    wait_accept(waited);
    capture(10, 1, 1'b0, 8'h00, 1'b0, busy_c, start_c, bv);
    check("after_reset_bits", 32'(bv), 32'h386);
    check("after_reset_cycles", 32'(busy_c), 32'd161);
    $display("frame 8N1 data=c3 div=1 cycles=%0d bits=%h", busy_c, bv);

    // Randomised frames against the model, with stray idle ticks
    noise_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      logic [7:0] d;
      logic [1:0] len;
      logic pe, po, s2;
      int dv;
      d   = 8'($urandom());
      len = 2'($urandom_range(0, 3));
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      dv  = $urandom_range(1, 4);
      drive(d, len, pe, po, s2, dv);
      wait_accept(waited);
      capture(1, dv, 1'b0, 8'($urandom()), 1'($urandom_range(0, 1)), busy_c, start_c, bv);
      $display("frame %0d data=%h len=%0d par_en=%0d odd=%0d stop2=%0d div=%0d cycles=%0d",
               f, d, 5 + int'(len), pe, po, s2, dv, busy_c);
      repeat ($urandom_range(0, 3)) @(negedge pclk);
    end

    repeat (5) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
